// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control FSM and datapath (rv_dp).
// Includes the FSM state enum, opcode/funct3 values, select encodings and the control bundle.
package rv_ctrl_pkg;

    localparam int unsigned OPW  = 7;
    localparam int unsigned F3W  = 3;
    localparam int unsigned SELW = 2;
    localparam int unsigned ALUW = 4;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU, S_ADDR, S_MEM_LD,
        S_WB_MEM, S_MEM_ST, S_BR_CMP, S_BR_TGT, S_J_TGT, S_JMP, S_ILLEGAL
    } state_t;

    localparam logic [OPW-1:0] OP_R      = 7'b0110011;
    localparam logic [OPW-1:0] OP_I      = 7'b0010011;
    localparam logic [OPW-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPW-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPW-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPW-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPW-1:0] OP_JALR   = 7'b1100111;

    localparam logic [F3W-1:0] F3_W   = 3'b010;
    localparam logic [F3W-1:0] F3_SW2 = 3'b110;
    localparam logic [F3W-1:0] F3_BEQ = 3'b000;
    localparam logic [F3W-1:0] F3_BNE = 3'b001;

    localparam logic PC_ALU   = 1'b0;
    localparam logic PC_PLUS4 = 1'b1;

    localparam logic [SELW-1:0] WB_MDR    = 2'd0;
    localparam logic [SELW-1:0] WB_ALUOUT = 2'd1;
    localparam logic [SELW-1:0] WB_PC     = 2'd2;

    localparam logic [SELW-1:0] IMM_J = 2'd0;
    localparam logic [SELW-1:0] IMM_B = 2'd1;
    localparam logic [SELW-1:0] IMM_S = 2'd2;
    localparam logic [SELW-1:0] IMM_L = 2'd3;

    localparam logic ALUA_REG = 1'b0;
    localparam logic ALUA_PCC = 1'b1;
    localparam logic ALUB_REG = 1'b0;
    localparam logic ALUB_IMM = 1'b1;

    localparam logic [ALUW-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALUW-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALUW-1:0] ALU_SLL  = 4'd2;
    localparam logic [ALUW-1:0] ALU_SLT  = 4'd3;
    localparam logic [ALUW-1:0] ALU_SLTU = 4'd4;
    localparam logic [ALUW-1:0] ALU_XOR  = 4'd5;
    localparam logic [ALUW-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALUW-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALUW-1:0] ALU_OR   = 4'd8;
    localparam logic [ALUW-1:0] ALU_AND  = 4'd9;

    localparam logic MUX_SW2 = 1'b1;

    // Every datapath select/enable driven by the controller in one bundle.
    typedef struct packed {
        logic            pcsourse;
        logic            pcwrite;
        logic            pccen;
        logic            irwrite;
        logic [SELW-1:0] wbsel;
        logic            regwen;
        logic [SELW-1:0] immsel;
        logic            asel;
        logic            bsel;
        logic [ALUW-1:0] alusel;
        logic            mdrwrite;
        logic            sw2_signal;
        logic            dmem_we;
    } ctl_t;

    function automatic ctl_t ctl_default();
        ctl_t c;
        c            = '0;
        c.pcsourse   = PC_PLUS4;
        c.wbsel      = WB_ALUOUT;
        c.immsel     = IMM_L;
        c.asel       = ALUA_REG;
        c.bsel       = ALUB_REG;
        c.alusel     = ALU_ADD;
        c.sw2_signal = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/rv_alu_dec.sv
// ALU operation decode from funct3 / funct7[5]; combinational.
module rv_alu_dec
    import rv_ctrl_pkg::*;
(
    input  logic [F3W-1:0]  funct3,
    input  logic            funct7_5,
    input  logic            is_rtype,
    output logic [ALUW-1:0] alusel
);

    always_comb begin
        alusel = ALU_ADD;
        case (funct3)
            3'b000:  alusel = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  alusel = ALU_SLL;
            3'b010:  alusel = ALU_SLT;
            3'b011:  alusel = ALU_SLTU;
            3'b100:  alusel = ALU_XOR;
            3'b101:  alusel = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  alusel = ALU_OR;
            default: alusel = ALU_AND;
        endcase
    end

endmodule

// File: rtl/rv_mc_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch..writeback and counts retired instructions.
// Define RV_SW2_EN to accept the SW2 store (funct3=110, stores 0-rs2).
module rv_mc_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned DPWIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DPWIDTH-1:0] instr,
    input  logic               zero,
    output logic               pcsourse,
    output logic               pcwrite,
    output logic               pccen,
    output logic               irwrite,
    output logic [SELW-1:0]    wbsel,
    output logic               regwen,
    output logic [SELW-1:0]    immsel,
    output logic               asel,
    output logic               bsel,
    output logic [ALUW-1:0]    alusel,
    output logic               mdrwrite,
    output logic               sw2_signal,
    output logic               dmem_we,
    output logic               illegal,
    output logic [DPWIDTH-1:0] instret
);

    state_t          state, state_nxt;
    ctl_t            ctl;
    logic            retire;
    logic            is_sw2;
    logic            taken;
    logic [ALUW-1:0] dec_alusel;
    logic [OPW-1:0]  opcode;
    logic [F3W-1:0]  funct3;
    logic            unused_instr_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign unused_instr_bits = ^{instr[DPWIDTH-1], instr[29:15], instr[11:7]};

`ifdef RV_SW2_EN
    assign is_sw2 = (opcode == OP_STORE) && (funct3 == F3_SW2);
`else
    assign is_sw2 = 1'b0;
`endif

    // BEQ takes on zero, BNE on !zero; funct3[0] distinguishes them.
    assign taken = (funct3 == F3_BNE) ? !zero : zero;

    rv_alu_dec u_alu_dec (
        .funct3   (funct3),
        .funct7_5 (instr[30]),
        .is_rtype (opcode == OP_R),
        .alusel   (dec_alusel)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ctl       = ctl_default();
        retire    = 1'b0;
        case (state)
            S_FETCH: begin
                ctl.irwrite  = 1'b1;
                ctl.pccen    = 1'b1;
                ctl.pcwrite  = 1'b1;
                ctl.pcsourse = PC_PLUS4;
                state_nxt    = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_R:      state_nxt = S_EXEC_R;
                    OP_I:      state_nxt = S_EXEC_I;
                    OP_LOAD:   state_nxt = (funct3 == F3_W) ? S_ADDR : S_ILLEGAL;
                    OP_STORE:  state_nxt = (funct3 == F3_W || is_sw2) ? S_ADDR : S_ILLEGAL;
                    OP_BRANCH: state_nxt = (funct3 == F3_BEQ || funct3 == F3_BNE) ? S_BR_CMP
                                                                                    : S_ILLEGAL;
                    OP_JAL,
                    OP_JALR:   state_nxt = S_J_TGT;
                    default:   state_nxt = S_ILLEGAL;
                endcase
            end
            S_EXEC_R: begin
                ctl.alusel = dec_alusel;
                state_nxt  = S_WB_ALU;
            end
            S_EXEC_I: begin
                ctl.bsel   = ALUB_IMM;
                ctl.immsel = IMM_L;
                ctl.alusel = dec_alusel;
                state_nxt  = S_WB_ALU;
            end
            S_WB_ALU: begin
                ctl.regwen = 1'b1;
                ctl.wbsel  = WB_ALUOUT;
                state_nxt  = S_FETCH;
                retire     = 1'b1;
            end
            S_ADDR: begin
                ctl.bsel   = ALUB_IMM;
                ctl.immsel = (opcode == OP_STORE) ? IMM_S : IMM_L;
                state_nxt  = (opcode == OP_STORE) ? S_MEM_ST : S_MEM_LD;
            end
            S_MEM_LD: begin
                ctl.mdrwrite = 1'b1;
                state_nxt    = S_WB_MEM;
            end
            S_WB_MEM: begin
                ctl.regwen = 1'b1;
                ctl.wbsel  = WB_MDR;
                state_nxt  = S_FETCH;
                retire     = 1'b1;
            end
            S_MEM_ST: begin
                ctl.dmem_we    = 1'b1;
                ctl.sw2_signal = is_sw2 ? MUX_SW2 : 1'b0;
                state_nxt      = S_FETCH;
                retire         = 1'b1;
            end
            S_BR_CMP: begin
                ctl.alusel = ALU_SUB;
                state_nxt  = taken ? S_BR_TGT : S_FETCH;
                retire     = !taken;
            end
            S_BR_TGT: begin
                ctl.asel   = ALUA_PCC;
                ctl.bsel   = ALUB_IMM;
                ctl.immsel = IMM_B;
                state_nxt  = S_JMP;
            end
            // Link write and target compute share a cycle; A was latched before the RF write.
            S_J_TGT: begin
                ctl.asel   = (opcode == OP_JAL) ? ALUA_PCC : ALUA_REG;
                ctl.immsel = (opcode == OP_JAL) ? IMM_J : IMM_L;
                ctl.bsel   = ALUB_IMM;
                ctl.regwen = 1'b1;
                ctl.wbsel  = WB_PC;
                state_nxt  = S_JMP;
            end
            S_JMP: begin
                ctl.pcwrite  = 1'b1;
                ctl.pcsourse = PC_ALU;
                state_nxt    = S_FETCH;
                retire       = 1'b1;
            end
            S_ILLEGAL: state_nxt = S_ILLEGAL;
            default:   state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         illegal <= 1'b0;
        else if (state_nxt == S_ILLEGAL) illegal <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         instret <= '0;
        else if (retire) instret <= instret + DPWIDTH'(1);
    end

    assign pcsourse   = ctl.pcsourse;
    assign pcwrite    = ctl.pcwrite;
    assign pccen      = ctl.pccen;
    assign irwrite    = ctl.irwrite;
    assign wbsel      = ctl.wbsel;
    assign regwen     = ctl.regwen;
    assign immsel     = ctl.immsel;
    assign asel       = ctl.asel;
    assign bsel       = ctl.bsel;
    assign alusel     = ctl.alusel;
    assign mdrwrite   = ctl.mdrwrite;
    assign sw2_signal = ctl.sw2_signal;
    assign dmem_we    = ctl.dmem_we;

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// Self-checking bench for rv_mc_ctrl: directed vector table, reset corner cases, random instruction stream.
module tb_rv_mc_ctrl;
    import rv_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        zero;
    logic        pcsourse, pcwrite, pccen, irwrite, regwen, asel, bsel;
    logic        mdrwrite, sw2_signal, dmem_we, illegal;
    logic [1:0]  wbsel, immsel;
    logic [3:0]  alusel;
    logic [31:0] instret;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_ret = '0;

    rv_mc_ctrl #(.DPWIDTH(32)) dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero),
        .pcsourse(pcsourse), .pcwrite(pcwrite), .pccen(pccen), .irwrite(irwrite),
        .wbsel(wbsel), .regwen(regwen), .immsel(immsel), .asel(asel), .bsel(bsel),
        .alusel(alusel), .mdrwrite(mdrwrite), .sw2_signal(sw2_signal),
        .dmem_we(dmem_we), .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef enum int {K_R, K_I, K_LW, K_SW, K_SW2, K_BR, K_JAL, K_JALR, K_ILL} kind_t;

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        int          cycles;
        logic        ill;
        string       name;
    } vec_t;

    function automatic kind_t classify(input logic [31:0] i);
        logic [6:0] op;
        logic [2:0] f3;
        op = i[6:0];
        f3 = i[14:12];
        if (op == 7'b0110011) return K_R;
        if (op == 7'b0010011) return K_I;
        if (op == 7'b0000011 && f3 == 3'b010) return K_LW;
        if (op == 7'b0100011 && f3 == 3'b010) return K_SW;
`ifdef RV_SW2_EN
        if (op == 7'b0100011 && f3 == 3'b110) return K_SW2;
`endif
        if (op == 7'b1100011 && (f3 == 3'b000 || f3 == 3'b001)) return K_BR;
        if (op == 7'b1101111) return K_JAL;
        if (op == 7'b1100111) return K_JALR;
        return K_ILL;
    endfunction

    function automatic logic br_taken(input logic [31:0] i, input logic z);
        return (i[14:12] == 3'b000) ? z : !z;
    endfunction

    function automatic int model_cycles(input logic [31:0] i, input logic z);
        case (classify(i))
            K_LW:    return 5;
            K_BR:    return br_taken(i, z) ? 5 : 3;
            K_ILL:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic f7b, input logic isr);
        case (f3)
            3'd0:    return (isr && f7b) ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return f7b ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // Expected control bundle for cycle k of an instruction (cycle 0 is fetch).
    function automatic ctl_t expect_ctl(input logic [31:0] i, input logic z, input int k);
        ctl_t  e;
        kind_t kd;
        e = '0;
        e.asel = ALUA_REG; e.bsel = ALUB_REG; e.alusel = ALU_ADD;
        e.immsel = IMM_L;  e.wbsel = WB_ALUOUT; e.pcsourse = PC_PLUS4;
        kd = classify(i);
        if (k == 0) begin
            e.irwrite = 1'b1; e.pccen = 1'b1; e.pcwrite = 1'b1; e.pcsourse = PC_PLUS4;
            return e;
        end
        if (k == 1) return e;
        case (kd)
            K_R, K_I: begin
                if (k == 2) begin
                    e.alusel = ref_alu(i[14:12], i[30], kd == K_R);
                    if (kd == K_I) begin e.bsel = ALUB_IMM; e.immsel = IMM_L; end
                end else if (k == 3) begin
                    e.regwen = 1'b1; e.wbsel = WB_ALUOUT;
                end
            end
            K_LW: begin
                if (k == 2) begin e.bsel = ALUB_IMM; e.immsel = IMM_L; end
                else if (k == 3) e.mdrwrite = 1'b1;
                else if (k == 4) begin e.regwen = 1'b1; e.wbsel = WB_MDR; end
            end
            K_SW, K_SW2: begin
                if (k == 2) begin e.bsel = ALUB_IMM; e.immsel = IMM_S; end
                else if (k == 3) begin e.dmem_we = 1'b1; e.sw2_signal = (kd == K_SW2); end
            end
            K_BR: begin
                if (k == 2) e.alusel = ALU_SUB;
                else if (k == 3) begin e.asel = ALUA_PCC; e.bsel = ALUB_IMM; e.immsel = IMM_B; end
                else if (k == 4) begin e.pcwrite = 1'b1; e.pcsourse = PC_ALU; end
            end
            K_JAL, K_JALR: begin
                if (k == 2) begin
                    e.asel   = (kd == K_JAL) ? ALUA_PCC : ALUA_REG;
                    e.immsel = (kd == K_JAL) ? IMM_J : IMM_L;
                    e.bsel   = ALUB_IMM; e.regwen = 1'b1; e.wbsel = WB_PC;
                end else if (k == 3) begin
                    e.pcwrite = 1'b1; e.pcsourse = PC_ALU;
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic ctl_t actual_ctl();
        ctl_t a;
        a.pcsourse = pcsourse; a.pcwrite = pcwrite; a.pccen = pccen; a.irwrite = irwrite;
        a.wbsel = wbsel; a.regwen = regwen; a.immsel = immsel; a.asel = asel; a.bsel = bsel;
        a.alusel = alusel; a.mdrwrite = mdrwrite; a.sw2_signal = sw2_signal; a.dmem_we = dmem_we;
        return a;
    endfunction

    task automatic check_ctl(input string name, input int k, input ctl_t exp_c);
        ctl_t a;
        a = actual_ctl();
        // PC source only matters when the PC is loaded.
        if (!exp_c.pcwrite) begin a.pcsourse = 1'b0; exp_c.pcsourse = 1'b0; end
        checks++;
        if (a !== exp_c) begin
            errors++;
            $display("FAIL ctl %s cycle %0d got=%h exp=%h", name, k, a, exp_c);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp_v);
        end
    endtask

    // Reset asserted at a negedge, released 1ns after a posedge so the next negedge is still FETCH.
    task automatic do_reset(input string name);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_ctl({name, "_rst"}, 0, expect_ctl(32'h0000_0013, 1'b0, 0));
        check_val({name, "_rst_instret"}, instret, 32'd0);
        check_val({name, "_rst_illegal"}, {31'd0, illegal}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_ret = '0;
    endtask

    task automatic run_instr(input logic [31:0] i, input logic z, input int n, input logic ill,
                             input string name);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k == 0) begin instr = i; zero = z; end
            #1;
            check_ctl(name, k, expect_ctl(i, z, k));
            if (k == 0) check_val({name, "_instret"}, instret, model_ret);
            check_val({name, "_illegal"}, {31'd0, illegal}, 32'd0);
        end
        if (!ill) begin
            model_ret = model_ret + 32'd1;
        end else begin
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                #1;
                check_ctl({name, "_ill"}, c + 2, expect_ctl(i, z, 2));
                check_val({name, "_ill_sticky"}, {31'd0, illegal}, 32'd1);
            end
            do_reset(name);
        end
    endtask

    function automatic logic [31:0] rand_instr(input int cls);
        logic [31:0] r;
        r = $urandom;
        case (cls)
            0: begin r[6:0] = OP_R; r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
            1: r[6:0] = OP_I;
            2: begin
                r[6:0] = OP_LOAD;
                if ($urandom_range(0, 3) != 0) r[14:12] = 3'b010;
            end
            3: begin
                r[6:0] = OP_STORE;
                case ($urandom_range(0, 3))
                    0:       r[14:12] = 3'b110;
                    1:       ;
                    default: r[14:12] = 3'b010;
                endcase
            end
            4: begin r[6:0] = OP_BRANCH; r[14:12] = 3'($urandom_range(0, 2)); end
            5: r[6:0] = OP_JAL;
            6: r[6:0] = OP_JALR;
            default: ;
        endcase
        return r;
    endfunction

    vec_t tbl[$];

    initial begin
        rst   = 1'b1;
        instr = '0;
        zero  = 1'b0;

        tbl.push_back('{32'h002081B3, 1'b0, 4, 1'b0, "add"});
        tbl.push_back('{32'h402081B3, 1'b0, 4, 1'b0, "sub"});
        tbl.push_back('{32'h4020D1B3, 1'b0, 4, 1'b0, "sra"});
        tbl.push_back('{32'h4030D193, 1'b0, 4, 1'b0, "srai"});
        tbl.push_back('{32'h80008093, 1'b0, 4, 1'b0, "addi_neg"});
        tbl.push_back('{32'h00208463, 1'b1, 5, 1'b0, "beq_taken"});
        tbl.push_back('{32'h00208463, 1'b0, 3, 1'b0, "beq_not"});
        tbl.push_back('{32'h00209463, 1'b0, 5, 1'b0, "bne_taken"});
        tbl.push_back('{32'h00209463, 1'b1, 3, 1'b0, "bne_not"});
        tbl.push_back('{32'h0040A283, 1'b0, 5, 1'b0, "lw"});
        tbl.push_back('{32'h0050A423, 1'b0, 4, 1'b0, "sw"});
        tbl.push_back('{32'h000080E7, 1'b0, 4, 1'b0, "jalr"});
        tbl.push_back('{32'h010000EF, 1'b0, 4, 1'b0, "jal"});
`ifdef RV_SW2_EN
        tbl.push_back('{32'h0050E423, 1'b0, 4, 1'b0, "sw2"});
`else
        tbl.push_back('{32'h0050E423, 1'b0, 2, 1'b1, "sw2_ill"});
`endif
        tbl.push_back('{32'h00008283, 1'b0, 2, 1'b1, "lb_ill"});
        tbl.push_back('{32'hFFFFFFFF, 1'b0, 2, 1'b1, "all_ones"});
        tbl.push_back('{32'h002081B3, 1'b0, 4, 1'b0, "add_after_rst"});

        #1;
        check_ctl("reset", 0, expect_ctl(32'h0, 1'b0, 0));
        check_val("reset_instret", instret, 32'd0);
        check_val("reset_illegal", {31'd0, illegal}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        foreach (tbl[v]) run_instr(tbl[v].instr, tbl[v].zero, tbl[v].cycles, tbl[v].ill, tbl[v].name);

        // Reset during MEM_LD: back to FETCH at once, no load writeback.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) begin instr = 32'h0040A283; zero = 1'b0; end
            #1;
            check_ctl("lw_rst", k, expect_ctl(32'h0040A283, 1'b0, k));
        end
        rst = 1'b1;
        #1;
        check_ctl("lw_rst_async", 0, expect_ctl(32'h0040A283, 1'b0, 0));
        check_val("lw_rst_instret", instret, 32'd0);
        @(posedge clk);
        #1;
        check_val("lw_rst_no_regwen", {31'd0, regwen}, 32'd0);
        rst = 1'b0;
        model_ret = '0;
        run_instr(32'h0040A283, 1'b0, 5, 1'b0, "lw_after_rst");

        for (int n = 0; n < 300; n++) begin
            logic [31:0] ri;
            logic        rz;
            ri = rand_instr(int'($urandom_range(0, 8)));
            rz = 1'($urandom_range(0, 1));
            run_instr(ri, rz, model_cycles(ri, rz), classify(ri) == K_ILL, "rand");
        end

        @(negedge clk);
        #1;
        check_val("final_instret", instret, model_ret);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
